// File: rtl/pulse.sv
// ---------------------------------------------------------------------------
// pulse -- rising-edge detector producing a registered one-cycle pulse.
//
// A level input is sampled (or synchronised), fed to a two-state machine,
// and a single-cycle pulse is emitted when the machine moves from IDLE
// (armed, last sample low) to HELD (disarmed, last sample high). A high
// level of any length yields exactly one pulse. Falling edges never pulse.
//
// Optional feature macro: PULSE_SYNC_EN
//   undefined : `in` is assumed synchronous to clk; one sampling flop,
//               latency from the sampling edge to out=1 is 1 cycle.
//   defined   : a SYNC_STAGES-deep synchronizer precedes the state machine,
//               so `in` may be asynchronous; latency is SYNC_STAGES cycles.
//
// Parameters:
//   SYNC_STAGES : synchronizer depth, legal 2..4 (used with PULSE_SYNC_EN).
//
// Ports:
//   clk   : input,  single clock, all state updates on its rising edge
//   reset : input,  synchronous active-high reset
//   in    : input,  level to be edge-detected
//   out   : output, registered one-cycle pulse per rising edge of in
//
// Reset puts every sampling/synchronizer flop at 1 and the machine in HELD,
// so a level that is already high when reset is released does not pulse;
// the input has to be seen low first.
// ---------------------------------------------------------------------------
module pulse #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    state_t state;
    logic   s;   // sampled input seen by the state machine

    // Reject an out-of-range depth at elaboration time.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("pulse: SYNC_STAGES must be in 2..4");
    end

`ifdef PULSE_SYNC_EN
    // Shift chain: bit 0 captures the raw input, the top bit is the
    // settled sample. Reset fills the chain with ones so the machine
    // stays disarmed until a genuine low has propagated through.
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];
`else
    // Single sampling flop; reset value 1 keeps the machine disarmed
    // for the first cycle after release.
    logic s_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q <= 1'b1;
        end else begin
            s_q <= in;
        end
    end

    assign s = s_q;
`endif

    // State machine with registered pulse output. out is set only on the
    // IDLE->HELD transition; since HELD always clears out and IDLE needs a
    // low sample to be re-entered, two adjacent pulses are impossible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HELD;
            out   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= HELD;
                        out   <= 1'b1;
                    end else begin
                        out   <= 1'b0;
                    end
                end
                HELD: begin
                    out <= 1'b0;
                    if (!s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= HELD;
                    out   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse.sv
// ---------------------------------------------------------------------------
// tb_pulse -- directed bench for pulse.
// Each scenario is a per-cycle table of (reset, in) values plus a table of
// expected out values, all zero except at hand-computed pulse positions.
// Row c is driven just after edge c-1 and out is checked 1 ns after edge c.
// A pulse for a high first sampled at row k is expected at row k + LAT.
// ---------------------------------------------------------------------------
module tb_pulse;

`ifdef PULSE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic in;
    logic out;

    pulse #(.SYNC_STAGES(3)) dut (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .out   (out)
    );

    // clock
    always #5 clk = ~clk;

    // stimulus tables and expected queue
    logic       stim_rst[$];
    logic       stim_in[$];
    logic [0:0] exp_q[$];

    int tests_run = 0;
    int failures  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic add(input logic r, input logic i, input int n);
        for (int k = 0; k < n; k++) begin
            stim_rst.push_back(r);
            stim_in.push_back(i);
            exp_q.push_back(1'b0);
        end
    endtask

    task automatic expect_pulse(input int idx);
        exp_q[idx] = 1'b1;
    endtask

    task automatic run_seq(input string name, input int n_pulses);
        int   seen;
        logic prev;
        seen = 0;
        prev = 1'b0;
        for (int c = 0; c < stim_in.size(); c++) begin
            reset = stim_rst[c];
            in    = stim_in[c];
            @(posedge clk);
            #1;
            check($sformatf("%s_out[%0d]", name, c), {31'b0, out}, {31'b0, exp_q[c]});
            check($sformatf("%s_adj[%0d]", name, c), {31'b0, prev & out}, 32'd0);
            if (out === 1'b1) seen++;
            prev = out;
        end
        check($sformatf("%s_count", name), seen, n_pulses);
        stim_rst.delete();
        stim_in.delete();
        exp_q.delete();
    endtask

    initial begin
        int k;
        reset = 1'b1;
        in    = 1'b0;

        // reset state: out low while reset is held
        add(1'b1, 1'b0, 3);
        run_seq("reset", 0);

        // low 5 / high 1, repeated 20 times -> 20 pulses
        add(1'b1, 1'b0, 1);
        for (int r = 0; r < 20; r++) begin
            add(1'b0, 1'b0, 5);
            k = stim_in.size();
            add(1'b0, 1'b1, 1);
            expect_pulse(k + LAT);
        end
        add(1'b0, 1'b0, LAT + 2);
        run_seq("rep20", 20);

        // long high of 50 cycles -> one pulse, nothing on the falling edge
        add(1'b1, 1'b0, 1);
        add(1'b0, 1'b0, 3);
        k = stim_in.size();
        add(1'b0, 1'b1, 50);
        expect_pulse(k + LAT);
        add(1'b0, 1'b0, LAT + 4);
        run_seq("long_high", 1);

        // toggle every cycle for 10 cycles -> 5 pulses, one every 2 cycles
        add(1'b1, 1'b0, 1);
        for (int r = 0; r < 5; r++) begin
            add(1'b0, 1'b0, 1);
            k = stim_in.size();
            add(1'b0, 1'b1, 1);
            expect_pulse(k + LAT);
        end
        add(1'b0, 1'b0, LAT + 2);
        run_seq("toggle", 5);

        // in high through reset and after release -> silent; then low, high -> one pulse
        add(1'b1, 1'b1, 2);
        add(1'b0, 1'b1, 10);
        add(1'b0, 1'b0, 1);
        k = stim_in.size();
        add(1'b0, 1'b1, 5);
        expect_pulse(k + LAT);
        add(1'b0, 1'b0, LAT + 2);
        run_seq("high_in_reset", 1);

        // in rises on the first cycle after reset release -> no pulse; later edge pulses
        add(1'b1, 1'b0, 2);
        add(1'b0, 1'b1, 5);
        add(1'b0, 1'b0, LAT + 2);
        k = stim_in.size();
        add(1'b0, 1'b1, 3);
        expect_pulse(k + LAT);
        add(1'b0, 1'b0, LAT + 2);
        run_seq("rise_at_release", 1);

        // reset on the edge the pulse would appear -> pulse dropped, no late pulse
        add(1'b1, 1'b0, 1);
        add(1'b0, 1'b0, 2);
        add(1'b0, 1'b1, LAT);
        add(1'b1, 1'b1, 1);
        add(1'b0, 1'b1, 5);
        add(1'b0, 1'b0, LAT + 2);
        k = stim_in.size();
        add(1'b0, 1'b1, 2);
        expect_pulse(k + LAT);
        add(1'b0, 1'b0, LAT + 2);
        run_seq("reset_on_pulse", 1);

        // single 0,1,0 rising edge: width 1 at the expected latency
        add(1'b1, 1'b0, 1);
        add(1'b0, 1'b0, 4);
        k = stim_in.size();
        add(1'b0, 1'b1, 1);
        expect_pulse(k + LAT);
        add(1'b0, 1'b0, LAT + 3);
        run_seq("single_edge", 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/pulse.md
PULSE -- requirements
Module: pulse

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of input synchronizer flops, legal range 2..4, used only when PULSE_SYNC_EN is defined.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in, input, 1 bit: level input to be edge-detected.
REQ-005 SHALL have port out, output, 1 bit: one-cycle pulse per rising edge of in.
REQ-006 SHALL have no other ports.

Function
REQ-007 SHALL define sampled input s as in registered once per clk, or as the SYNC_STAGES-deep synchronizer output when PULSE_SYNC_EN is defined.
REQ-008 SHALL use a two-state machine: IDLE (last sample low, armed) and HELD (last sample high, disarmed).
REQ-009 SHALL transition IDLE->HELD when s=1, and HELD->IDLE when s=0; otherwise the state is unchanged.
REQ-010 SHALL drive out from a flop, never combinationally from in.
REQ-011 SHALL assert out for exactly one clk cycle, on the edge where the state moves IDLE->HELD.
REQ-012 SHALL have a latency from the first clk edge sampling in=1 (previous sample 0) to out=1 of 1 cycle without the macro, and SYNC_STAGES cycles with it.
REQ-013 SHALL produce exactly one pulse for a high level of any length, including a level held indefinitely.
REQ-014 SHALL produce a pulse for a 1-cycle-wide high (0,1,0) and a pulse for each high of alternating 0,1,0,1 (a pulse every 2 cycles).
REQ-015 SHALL never assert out on two consecutive cycles.
REQ-016 SHALL never generate a pulse on a falling edge.
REQ-017 SHALL treat X/Z on in as don't-care for synthesis; no X-propagation handling is required.

Reset
REQ-018 SHALL, when reset=1 at a clk edge, force out=0, the state to HELD, and all synchronizer flops to 1.
REQ-019 SHALL ignore reset between clk edges (synchronous).
REQ-020 SHALL, because reset leaves the block in HELD, not pulse if in is high while reset is released; a pulse requires in to be sampled low first.
REQ-021 SHALL, on reset asserted mid-pulse, force out=0 at that edge and drop any pending pulse.
REQ-022 SHALL, when in goes high in the same cycle reset deasserts, produce no pulse.

Configuration
REQ-023 SHALL support macro PULSE_SYNC_EN.
REQ-024 SHALL, when PULSE_SYNC_EN is defined, insert a SYNC_STAGES-flop synchronizer ahead of the state machine so that in may be asynchronous, giving latency SYNC_STAGES cycles.
REQ-025 SHALL, when PULSE_SYNC_EN is undefined, assume in is synchronous to clk, use a single sampling flop, and give latency 1 cycle.
REQ-026 SHALL behave identically in both builds apart from latency.

Verification
REQ-027 SHALL cover: reset 1 cycle, then in low 5 cycles and high 1 cycle, repeated 20 times -> exactly 20 single-cycle pulses, each 1 cycle (macro off) after the in=1 sample.
REQ-028 SHALL cover: in held high 50 cycles after a low -> exactly one pulse; out=0 for the other 49 cycles.
REQ-029 SHALL cover: in toggled every cycle for 10 cycles -> 5 pulses, never two adjacent out=1 cycles.
REQ-030 SHALL cover: in=1 during reset and held high after release -> out=0 throughout; then in low 1 cycle and high -> one pulse.
REQ-031 SHALL cover: reset asserted on the cycle out would assert -> out=0 and no later pulse for that edge.
REQ-032 SHALL cover, with PULSE_SYNC_EN defined and SYNC_STAGES=3: a single rising edge -> pulse 3 cycles after the first sample, width 1.
